// File: rtl/wallace_pkg.sv
// wallace_pkg
//   Shared definitions for the wallace multiply-accumulate datapath.
//   PROD_W      : width of the multiplier product (and accumulator input)
//   OPND_W      : width of one multiplier operand
//   acc_state_t : accumulator control states
package wallace_pkg;

  localparam int PROD_W = 256;
  localparam int OPND_W = 128;

  // IDLE  : waiting for the first beat of a burst
  // ACCUM : burst in progress, summing beats
  // HOLD  : result presented on the output handshake
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/wallace_acc_adder.sv
// wallace_acc_adder
//   Ripple-carry adder, W bits wide, carry-in fixed at zero.
//   a, b : unsigned addends
//   sum  : a + b modulo 2^W
//   cout : carry out of bit W-1
module wallace_acc_adder #(
  parameter int W = 264
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  // The carry is a procedural variable rippling through the loop so the
  // chain is expressed bit by bit without a self-referencing vector net.
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/wallace_accumulator.sv
// wallace_accumulator
//   Sums a burst of unsigned products (terminated by in_last) and presents
//   sum, beat count and sticky overflow on a held output handshake.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   The producer holds valid and data stable until ready is seen; ready
//   never depends combinationally on valid. in_ready is low only in HOLD,
//   out_valid is high only in HOLD, both decoded from the state register.
//
//   Ports
//     clk, rst_n            : clock, synchronous active-low reset
//     in_valid / in_ready   : input beat handshake
//     in_product, in_last   : beat data and end-of-burst marker
//     out_valid / out_ready : result handshake
//     out_sum               : burst sum modulo 2^ACC_W
//     out_count             : beats in the burst, saturating
//     out_overflow          : a carry left the accumulator during the burst
//     state                 : current control state (debug observation)
module wallace_accumulator
  import wallace_pkg::*;
#(
  parameter int PROD_W = wallace_pkg::PROD_W,
  parameter int ACC_W  = 264,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow,
  output acc_state_t        state
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;

  assign prod_ext = ACC_W'(in_product);

  wallace_acc_adder #(
    .W (ACC_W)
  ) u_adder (
    .a    (acc),
    .b    (prod_ext),
    .sum  (acc_sum),
    .cout (carry)
  );

  // Count sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // First beat loads rather than adds, so no clear cycle is needed
          // between bursts.
          if (in_valid) begin
            acc   <= prod_ext;
            cnt   <= CNT_W'(1);
            ovf   <= 1'b0;
            state <= in_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            ovf <= ovf | carry;
            if (in_last) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state != HOLD);
  assign out_valid    = (state == HOLD);
  assign out_sum      = acc;
  assign out_count    = cnt;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_wallace_accumulator.sv
// tb_wallace_accumulator
//   Three instances share one stimulus stream: d0 with default widths,
//   d1 with a 256-bit accumulator, d2 with a 2-bit beat counter.
module tb_wallace_accumulator;

  localparam int PW = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_product = '0;

  logic         in_ready0, in_ready1, in_ready2;
  logic         out_valid0, out_valid1, out_valid2;
  logic [263:0] out_sum0, out_sum2;
  logic [255:0] out_sum1;
  logic [15:0]  out_count0, out_count1;
  logic [1:0]   out_count2;
  logic         out_ovf0, out_ovf1, out_ovf2;
  wallace_pkg::acc_state_t st0, st1, st2;

  wallace_accumulator d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0),
    .out_overflow(out_ovf0), .state(st0)
  );

  wallace_accumulator #(.ACC_W(256)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1),
    .out_overflow(out_ovf1), .state(st1)
  );

  wallace_accumulator #(.CNT_W(2)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2),
    .out_overflow(out_ovf2), .state(st2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0]  burst_q[$];
  logic [263:0]   exp_q[$];

  typedef struct {
    int           n;
    logic [PW-1:0] beat[5];
    int           gap;
    int           hold;
    logic [263:0] sum0;
    logic [15:0]  cnt0;
    logic         ovf0;
    logic [255:0] sum1;
    logic         ovf1;
    logic [1:0]   cnt2;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int n,
                         input logic [PW-1:0] b0, input logic [PW-1:0] b1,
                         input logic [PW-1:0] b2, input logic [PW-1:0] b3,
                         input logic [PW-1:0] b4, input int gap, input int hold,
                         input logic [263:0] s0, input logic [15:0] c0, input logic o0,
                         input logic [255:0] s1, input logic o1, input logic [1:0] c2);
    vecs[idx].n = n;
    vecs[idx].beat[0] = b0; vecs[idx].beat[1] = b1; vecs[idx].beat[2] = b2;
    vecs[idx].beat[3] = b3; vecs[idx].beat[4] = b4;
    vecs[idx].gap = gap; vecs[idx].hold = hold;
    vecs[idx].sum0 = s0; vecs[idx].cnt0 = c0; vecs[idx].ovf0 = o0;
    vecs[idx].sum1 = s1; vecs[idx].ovf1 = o1; vecs[idx].cnt2 = c2;
  endtask

  // Reference: true sum with ample headroom; wrap and overflow fall out of
  // comparing it against 2^acc_w, count is the beat total clipped.
  task automatic model(input int acc_w, input int cnt_w,
                       output logic [299:0] s, output logic [299:0] c, output logic o);
    logic [299:0] tot;
    logic [299:0] cmax;
    tot = '0;
    foreach (burst_q[i]) tot = tot + 300'(burst_q[i]);
    o = (tot >> acc_w) != 0;
    s = tot & ((300'(1) << acc_w) - 300'(1));
    cmax = (300'(1) << cnt_w) - 300'(1);
    c = (300'(burst_q.size()) > cmax) ? cmax : 300'(burst_q.size());
  endtask

  // Driver: presents every beat of burst_q with `gap` idle cycles between
  // beats; returns one cycle after the last beat transferred.
  task automatic send_beats(input int gap);
    int n;
    n = burst_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          chk("idle_out_valid", out_valid0, 0);
          step();
        end
      end
      in_valid   = 1'b1;
      in_product = burst_q[i];
      in_last    = (i == n - 1);
      chk("beat_out_valid", out_valid0, 0);
      for (int w = 0; w < 20 && !in_ready0; w++) step();
      chk("beat_in_ready", in_ready0, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Checks the held result for hold+1 cycles, completing the output
  // transfer on the last of them.
  task automatic check_hold(input int hold, input logic [15:0] c0, input logic o0,
                            input logic [255:0] s1, input logic o1, input logic [1:0] c2);
    logic [263:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int k = 0; k <= hold; k++) begin
      out_ready = (k == hold);
      chk("hold_out_valid0", out_valid0, 1);
      chk("hold_out_valid1", out_valid1, 1);
      chk("hold_out_valid2", out_valid2, 1);
      chk("hold_in_ready0", in_ready0, 0);
      chk("hold_in_ready2", in_ready2, 0);
      chk("sum0", out_sum0, e);
      chk("count0", out_count0, c0);
      chk("ovf0", out_ovf0, o0);
      chk("sum1", out_sum1, s1);
      chk("count1", out_count1, c0);
      chk("ovf1", out_ovf1, o1);
      chk("sum2", out_sum2, e);
      chk("count2", out_count2, c2);
      chk("ovf2", out_ovf2, o0);
      step();
    end
    out_ready = 1'b0;
    chk("after_out_valid0", out_valid0, 0);
    chk("after_in_ready0", in_ready0, 1);
    chk("after_out_valid1", out_valid1, 0);
  endtask

  function automatic logic [PW-1:0] rand_beat();
    logic [PW-1:0] r;
    r = '0;
    case ($urandom_range(0, 3))
      0: r = '1;
      1: r = PW'($urandom_range(0, 100));
      default: for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom();
    endcase
    return r;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [PW-1:0] ones;
    logic [299:0] s0, c0, s1, c1, s2, c2;
    logic o0, o1, o2;
    ones = '1;

    set_vec(0, 1, 256'd43630835, '0, '0, '0, '0, 0, 0,
            264'd43630835, 16'd1, 1'b0, 256'd43630835, 1'b0, 2'd1);
    set_vec(1, 3, 256'd10, 256'd20, 256'd30, '0, '0, 2, 5,
            264'd60, 16'd3, 1'b0, 256'd60, 1'b0, 2'd3);
    set_vec(2, 2, ones, 256'd2, '0, '0, '0, 0, 1,
            (264'd1 << 256) + 264'd1, 16'd2, 1'b0, 256'd1, 1'b1, 2'd2);
    set_vec(3, 1, 256'd5, '0, '0, '0, '0, 0, 0,
            264'd5, 16'd1, 1'b0, 256'd5, 1'b0, 2'd1);
    set_vec(4, 5, 256'd1, 256'd1, 256'd1, 256'd1, 256'd1, 0, 0,
            264'd5, 16'd5, 1'b0, 256'd5, 1'b0, 2'd3);

    // reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_sum", out_sum0, 0);
    chk("rst_out_count", out_count0, 0);
    chk("rst_out_ovf", out_ovf0, 0);
    rst_n = 1'b1;

    // table-driven bursts
    for (int v = 0; v < 5; v++) begin
      burst_q.delete();
      for (int i = 0; i < vecs[v].n; i++) burst_q.push_back(vecs[v].beat[i]);
      exp_q.push_back(vecs[v].sum0);
      send_beats(vecs[v].gap);
      check_hold(vecs[v].hold, vecs[v].cnt0, vecs[v].ovf0,
                 vecs[v].sum1, vecs[v].ovf1, vecs[v].cnt2);
    end

    // back-to-back: in_valid never drops, A = {1, 2 last}, B = {4 last}
    out_ready = 1'b1;
    in_valid = 1'b1; in_product = 256'd1; in_last = 1'b0;
    step();
    in_product = 256'd2; in_last = 1'b1;
    chk("b2b_a2_ready", in_ready0, 1);
    step();
    in_product = 256'd4; in_last = 1'b1;
    chk("b2b_a_valid", out_valid0, 1);
    chk("b2b_bubble_ready", in_ready0, 0);
    chk("b2b_a_sum", out_sum0, 3);
    chk("b2b_a_count", out_count0, 2);
    step();
    chk("b2b_gap_valid", out_valid0, 0);
    chk("b2b_b_ready", in_ready0, 1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_b_valid", out_valid0, 1);
    chk("b2b_b_sum", out_sum0, 4);
    chk("b2b_b_count", out_count0, 1);
    step();
    out_ready = 1'b0;
    chk("b2b_end_valid", out_valid0, 0);

    // reset in ACCUM discards the partial burst
    in_valid = 1'b1; in_product = 256'd7; in_last = 1'b0;
    step();
    in_product = 256'd8;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_ready", in_ready0, 1);
    chk("mid_rst_valid", out_valid0, 0);
    in_valid = 1'b1; in_product = 256'd9; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("mid_rst_hold_valid", out_valid0, 1);
    chk("mid_rst_sum", out_sum0, 9);
    chk("mid_rst_count", out_count0, 1);
    chk("mid_rst_ovf", out_ovf0, 0);
    step();
    chk("hold_stays_valid", out_valid0, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("hold_rst_valid", out_valid0, 0);
    chk("hold_rst_ready", in_ready0, 1);

    // randomized bursts against the reference model
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 6);
      burst_q.delete();
      for (int i = 0; i < n; i++) burst_q.push_back(rand_beat());
      model(264, 16, s0, c0, o0);
      model(256, 16, s1, c1, o1);
      model(264, 2, s2, c2, o2);
      exp_q.push_back(s0[263:0]);
      send_beats($urandom_range(0, 2));
      check_hold($urandom_range(0, 3), c0[15:0], o0, s1[255:0], o1, c2[1:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
